// File: rtl/lcd_ctrl.sv
// HD44780 write-only controller for the DE2 character LCD, fed by the LSU LCD MMIO strobe.
// Runs power-on init, then turns each CPU write into one RS/DATA/EN cycle followed by an execution wait.
module lcd_ctrl #(
    parameter int unsigned POR_CYC       = 750_000,
    parameter int unsigned SETUP_CYC     = 2,
    parameter int unsigned EN_CYC        = 12,
    parameter int unsigned HOLD_CYC      = 2,
    parameter int unsigned EXEC_CYC      = 2_000,
    parameter int unsigned LONG_EXEC_CYC = 82_000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_lcd_vld,
    input  logic [31:0] i_lcd_reg,
    output logic [7:0]  o_lcd_data,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic        o_lcd_en,
    output logic        o_lcd_on,
    output logic        o_lcd_blon,
    output logic        o_busy,
    output logic        o_ovf
);

    localparam int unsigned MAX_A   = (POR_CYC > LONG_EXEC_CYC) ? POR_CYC : LONG_EXEC_CYC;
    localparam int unsigned MAX_B   = (EXEC_CYC > EN_CYC) ? EXEC_CYC : EN_CYC;
    localparam int unsigned MAX_C   = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
    localparam int unsigned MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned MAX_CYC = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;
    localparam int unsigned INIT_N  = 4;

    localparam logic [2:0] S_POR   = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_SETUP = 3'd2;
    localparam logic [2:0] S_PULSE = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;
    localparam logic [2:0] S_EXEC  = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       init_q, init_d;
    logic             pend_vld_q, pend_vld_d;
    logic [10:0]      pend_q, pend_d;
    logic [7:0]       data_q, data_d;
    logic             rs_q, rs_d;
    logic             en_q, en_d;
    logic             on_q, on_d;
    logic             blon_q, blon_d;
    logic             busy_q, busy_d;
    logic             ovf_q, ovf_d;

    logic             launch, launch_cpu, pop;
    logic [10:0]      launch_ent;
    logic [10:0]      strobe_ent;
    logic             long_exec;
    logic [CNT_W-1:0] exec_lim;
    logic             unused_reg_bits;

    // Entry layout: {blon, on, rs, db}
    assign strobe_ent      = {i_lcd_reg[30], i_lcd_reg[31], i_lcd_reg[8], i_lcd_reg[7:0]};
    assign unused_reg_bits = ^i_lcd_reg[29:9];

    // Clear and home need the long execution wait.
    assign long_exec = !rs_q && (data_q != 8'h00) && (data_q <= 8'h03);
    assign exec_lim  = long_exec ? CNT_W'(LONG_EXEC_CYC - 1) : CNT_W'(EXEC_CYC - 1);

    function automatic logic [7:0] init_db(input logic [1:0] idx);
        case (idx)
            2'd0:    init_db = 8'h38;
            2'd1:    init_db = 8'h0C;
            2'd2:    init_db = 8'h01;
            default: init_db = 8'h06;
        endcase
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_POR;
            cnt_q      <= '0;
            init_q     <= '0;
            pend_vld_q <= 1'b0;
            pend_q     <= '0;
            data_q     <= '0;
            rs_q       <= 1'b0;
            en_q       <= 1'b0;
            on_q       <= 1'b1;
            blon_q     <= 1'b0;
            busy_q     <= 1'b1;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            init_q     <= init_d;
            pend_vld_q <= pend_vld_d;
            pend_q     <= pend_d;
            data_q     <= data_d;
            rs_q       <= rs_d;
            en_q       <= en_d;
            on_q       <= on_d;
            blon_q     <= blon_d;
            busy_q     <= busy_d;
            ovf_q      <= ovf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        init_d     = init_q;
        pend_vld_d = pend_vld_q;
        pend_d     = pend_q;
        data_d     = data_q;
        rs_d       = rs_q;
        on_d       = on_q;
        blon_d     = blon_q;
        ovf_d      = ovf_q;
        launch     = 1'b0;
        launch_cpu = 1'b0;
        launch_ent = '0;
        pop        = 1'b0;

        case (state_q)
            S_POR: begin
                if (cnt_q == CNT_W'(POR_CYC - 1)) begin
                    launch     = 1'b1;
                    launch_ent = {3'b000, init_db(init_q[1:0])};
                    init_d     = init_q + 3'd1;
                end
            end
            S_IDLE: begin
                cnt_d = '0;
                // A strobe that landed in the slot on the last EXEC cycle launches from here.
                if (pend_vld_q) begin
                    launch     = 1'b1;
                    launch_cpu = 1'b1;
                    launch_ent = pend_q;
                    pop        = 1'b1;
                end
            end
            S_SETUP: begin
                if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
                    state_d = S_PULSE;
                    cnt_d   = '0;
                end
            end
            S_PULSE: begin
                if (cnt_q == CNT_W'(EN_CYC - 1)) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end
            end
            S_HOLD: begin
                if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin
                    state_d = S_EXEC;
                    cnt_d   = '0;
                end
            end
            S_EXEC: begin
                if (cnt_q == exec_lim) begin
                    if (init_q < 3'(INIT_N)) begin
                        launch     = 1'b1;
                        launch_ent = {3'b000, init_db(init_q[1:0])};
                        init_d     = init_q + 3'd1;
                    end else if (pend_vld_q) begin
                        launch     = 1'b1;
                        launch_cpu = 1'b1;
                        launch_ent = pend_q;
                        pop        = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = S_POR;
                cnt_d   = '0;
            end
        endcase

        if (pop) begin
            pend_vld_d = 1'b0;
        end

        // Strobe accept: direct launch, fill the (possibly just freed) slot, or drop.
        if (i_lcd_vld) begin
            if (state_q == S_IDLE && !pend_vld_q) begin
                launch     = 1'b1;
                launch_cpu = 1'b1;
                launch_ent = strobe_ent;
            end else if (!pend_vld_q || pop) begin
                pend_vld_d = 1'b1;
                pend_d     = strobe_ent;
            end else begin
                ovf_d = 1'b1;
            end
        end

        if (launch) begin
            state_d = S_SETUP;
            cnt_d   = '0;
            data_d  = launch_ent[7:0];
            rs_d    = launch_ent[8];
            if (launch_cpu) begin
                on_d   = launch_ent[9];
                blon_d = launch_ent[10];
            end
        end
    end

    assign en_d   = (state_d == S_PULSE);
    assign busy_d = (state_d != S_IDLE) || pend_vld_d;

    assign o_lcd_data = data_q;
    assign o_lcd_rs   = rs_q;
    assign o_lcd_rw   = 1'b0;
    assign o_lcd_en   = en_q;
    assign o_lcd_on   = on_q;
    assign o_lcd_blon = blon_q;
    assign o_busy     = busy_q;
    assign o_ovf      = ovf_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl with short timing parameters; expected timelines are hand-derived.
module tb_lcd_ctrl;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_lcd_vld;
    logic [31:0] i_lcd_reg;
    logic [7:0]  o_lcd_data;
    logic        o_lcd_rs;
    logic        o_lcd_rw;
    logic        o_lcd_en;
    logic        o_lcd_on;
    logic        o_lcd_blon;
    logic        o_busy;
    logic        o_ovf;

    int n_vec = 0;
    int n_err = 0;

    lcd_ctrl #(
        .POR_CYC      (10),
        .SETUP_CYC    (2),
        .EN_CYC       (3),
        .HOLD_CYC     (2),
        .EXEC_CYC     (5),
        .LONG_EXEC_CYC(20)
    ) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_lcd_vld (i_lcd_vld),
        .i_lcd_reg (i_lcd_reg),
        .o_lcd_data(o_lcd_data),
        .o_lcd_rs  (o_lcd_rs),
        .o_lcd_rw  (o_lcd_rw),
        .o_lcd_en  (o_lcd_en),
        .o_lcd_on  (o_lcd_on),
        .o_lcd_blon(o_lcd_blon),
        .o_busy    (o_busy),
        .o_ovf     (o_ovf)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_en"},   32'(o_lcd_en),   32'h0);
        chk({tag, "_data"}, 32'(o_lcd_data), 32'h0);
        chk({tag, "_rs"},   32'(o_lcd_rs),   32'h0);
        chk({tag, "_rw"},   32'(o_lcd_rw),   32'h0);
        chk({tag, "_on"},   32'(o_lcd_on),   32'h1);
        chk({tag, "_blon"}, 32'(o_lcd_blon), 32'h0);
        chk({tag, "_busy"}, 32'(o_busy),     32'h1);
        chk({tag, "_ovf"},  32'(o_ovf),      32'h0);
    endtask

    // Edge e after reset release: POR e0..9, pulses at e12, e24, e36 (0x01), e63, IDLE at e73.
    task automatic run_init(input string tag);
        logic exp_en;
        for (int e = 1; e <= 73; e++) begin
            tick();
            exp_en = (e >= 12 && e <= 14) || (e >= 24 && e <= 26) ||
                     (e >= 36 && e <= 38) || (e >= 63 && e <= 65);
            chk({tag, "_en"}, 32'(o_lcd_en), 32'(exp_en));
            if (e == 12) chk({tag, "_db0"}, 32'({o_lcd_rs, o_lcd_data}), 32'h038);
            if (e == 24) chk({tag, "_db1"}, 32'({o_lcd_rs, o_lcd_data}), 32'h00C);
            if (e == 36) chk({tag, "_db2"}, 32'({o_lcd_rs, o_lcd_data}), 32'h001);
            if (e == 63) chk({tag, "_db3"}, 32'({o_lcd_rs, o_lcd_data}), 32'h006);
            if (e == 72) chk({tag, "_busy_last_exec"}, 32'(o_busy), 32'h1);
        end
        chk({tag, "_idle_busy"}, 32'(o_busy), 32'h0);
        chk({tag, "_on"},        32'(o_lcd_on), 32'h1);
        chk({tag, "_blon"},      32'(o_lcd_blon), 32'h0);
    endtask

    // k counts edges after the launching strobe; psN is the SETUP start of the Nth transfer (-1 unused).
    task automatic run_seq(input string tag, input int n_end,
                           input int ps0, input logic [8:0] e0,
                           input int ps1, input logic [8:0] e1,
                           input int ps2, input logic [8:0] e2,
                           input int ka, input logic [31:0] rega,
                           input int kb, input logic [31:0] regb);
        logic exp_en;
        for (int k = 0; k <= n_end; k++) begin
            exp_en = (k >= ps0 + 2 && k <= ps0 + 4) ||
                     (ps1 >= 0 && k >= ps1 + 2 && k <= ps1 + 4) ||
                     (ps2 >= 0 && k >= ps2 + 2 && k <= ps2 + 4);
            chk({tag, "_en"},   32'(o_lcd_en), 32'(exp_en));
            chk({tag, "_busy"}, 32'(o_busy),   32'(k != n_end));
            if (k == ps0) chk({tag, "_db0"}, 32'({o_lcd_rs, o_lcd_data}), 32'(e0));
            if (k == ps1) chk({tag, "_db1"}, 32'({o_lcd_rs, o_lcd_data}), 32'(e1));
            if (k == ps2) chk({tag, "_db2"}, 32'({o_lcd_rs, o_lcd_data}), 32'(e2));
            if (k == ka) begin
                i_lcd_vld = 1'b1;
                i_lcd_reg = rega;
            end else if (k == kb) begin
                i_lcd_vld = 1'b1;
                i_lcd_reg = regb;
            end else begin
                i_lcd_vld = 1'b0;
                i_lcd_reg = 32'h0;
            end
            tick();
        end
        i_lcd_vld = 1'b0;
    endtask

    task automatic strobe(input logic [31:0] r);
        i_lcd_vld = 1'b1;
        i_lcd_reg = r;
        tick();
        i_lcd_vld = 1'b0;
        i_lcd_reg = 32'h0;
    endtask

    initial begin
        i_rst_n   = 1'b0;
        i_lcd_vld = 1'b0;
        i_lcd_reg = 32'h0;
        repeat (3) tick();
        chk_reset_outputs("reset");
        i_rst_n = 1'b1;

        // 1: power-on init
        run_init("init");

        // 2: data write from IDLE, ON/BLON taken from the register
        strobe(32'hC000_0141);
        chk("wr_on",   32'(o_lcd_on),   32'h1);
        chk("wr_blon", 32'(o_lcd_blon), 32'h1);
        run_seq("wr", 12, 0, 9'h141, -1, 9'h0, -1, 9'h0, -1, 32'h0, -1, 32'h0);

        // 3: clear then a command queued behind it; long EXEC, no IDLE gap
        strobe(32'h0000_0001);
        run_seq("clr", 39, 0, 9'h001, 27, 9'h080, -1, 9'h0, 0, 32'h0000_0080, -1, 32'h0);
        chk("clr_ovf", 32'(o_ovf), 32'h0);

        // 5: strobe on the EXEC-exit cycle with the slot full
        strobe(32'hC000_0150);
        run_seq("exit", 36, 0, 9'h150, 12, 9'h151, 24, 9'h152, 0, 32'hC000_0151, 11, 32'hC000_0152);
        chk("exit_ovf", 32'(o_ovf), 32'h0);

        // 4: three back-to-back strobes, third dropped
        strobe(32'h0000_0131);
        chk("ovf_on", 32'(o_lcd_on), 32'h0);
        run_seq("ovf", 24, 0, 9'h131, 12, 9'h132, -1, 9'h0, 0, 32'h0000_0132, 1, 32'h0000_0133);
        chk("ovf_set",   32'(o_ovf),      32'h1);
        chk("ovf_db",    32'(o_lcd_data), 32'h32);
        repeat (5) tick();
        chk("ovf_stick", 32'(o_ovf),      32'h1);

        // 6: reset in the middle of an EN pulse
        strobe(32'h0000_0155);
        tick();
        tick();
        chk("mid_en_hi", 32'(o_lcd_en), 32'h1);
        i_rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_rst");
        tick();
        i_rst_n = 1'b1;
        run_init("reinit");
        chk("reinit_ovf", 32'(o_ovf), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
